j_wgt_deserializer: RTL and testbench
=====================================

# j_wgt_deserializer

Bit-serial weight receiver sitting directly downstream of the weight shifter. Consumes the shifter's `serial_output` / `serial_start` / `serial_en` stream (LSB-first, `SHIFT_WIDTH` bits per valid beat) and reassembles the 8-bit weights. Completed weights go into a small FIFO with a valid/ready output port for the PE array loader. The shifter has no backpressure, so the block absorbs rate mismatch and flags any loss.

## Interface

Parameters:
- `SHIFT_WIDTH`, 1: bits per serial beat; legal values 1, 2, 4, 8.
- `FIFO_DEPTH`, 4: number of weight entries; power of two, ≥2.

Ports:
- `clk`  in  1: single clock; all logic rising-edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `serial_output`  in  SHIFT_WIDTH: serial weight beat from the shifter.
- `serial_start`  in  1: qualifies the first beat of a stream; meaningful only with `serial_en`=1.
- `serial_en`  in  1: beat valid.
- `out_valid`  out  1: FIFO head holds a weight.
- `out_data`  out  8: FIFO head weight.
- `out_ready`  in  1: consumer accepts the head when `out_valid && out_ready`.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1: occupied entries.
- `overflow`  out  1: sticky; a completed weight was dropped because the FIFO was full.
- `partial_drop`  out  1: sticky; `serial_start` arrived mid-word.
- `clear_err`  in  1: synchronous clear of both sticky flags.

## Operation

- Beats per word: `BPW = 8/SHIFT_WIDTH`.
- Beat counter `beat` ranges 0..BPW-1. Assembly register `asm[7:0]`.
- A beat is any cycle with `serial_en`=1. Cycles with `serial_en`=0 are ignored entirely, whatever the values of `serial_output` and `serial_start`.
- Beat write: `asm[beat*SHIFT_WIDTH +: SHIFT_WIDTH] = serial_output`.
- If `beat` = BPW-1, the assembled word (`asm` with the final slice merged) is pushed and `beat` wraps to 0. Otherwise `beat` increments.
- If `serial_start`=1 on a beat while `beat`≠0:
  - The partial word is discarded and `partial_drop` is set.
  - The start beat is taken as beat 0 of a new word.
- `serial_start` with `beat`=0 is normal and raises no flag.
- When `SHIFT_WIDTH`=8, every beat is a complete word and `partial_drop` can never set.
- FIFO is circular, with read/write pointers of clog2(FIFO_DEPTH) bits that wrap modulo depth.
- Push when `fifo_count`=FIFO_DEPTH and no pop in the same cycle: the word is dropped and `overflow` is set. FIFO contents are unchanged.
- Push and pop in the same cycle:
  - Always legal, including when the FIFO is full.
  - The word is written and the head advances; `fifo_count` is unchanged.
- Pop with the FIFO empty is impossible, because `out_valid`=0.
- Words leave in arrival order. With the shifter's descending-address read, this gives weights from the highest address first.
- `clear_err`: flags clear on the next edge. If a set event occurs in the same cycle, set wins.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `fifo_count`=0, `overflow`=0, `partial_drop`=0. Internally `beat`=0 and `asm`=0.
- Reset takes effect asynchronously, including mid-word and mid-FIFO. Partial words and FIFO contents are lost.
- Latency: the word is pushed on the clock edge that samples its final beat. On that cycle:
  - `out_valid` rises, unless the FIFO was non-empty already.
  - `out_data` shows the word if the FIFO was empty.
- So latency is 1 cycle from the final beat's presentation to `out_valid`.
- `out_data`/`out_valid` are registered FIFO head state and do not depend combinationally on `out_ready`.
- `out_data` holds stable while `out_valid && !out_ready`.
- After a pop, the next head appears on the following cycle. Back-to-back pops sustain 1 word/cycle.
- Flags rise on the edge after the offending beat.
- Sustained input rate is at most 1 word per BPW cycles. With `out_ready` held high, the FIFO never exceeds 1 entry.

## Test plan

- SHIFT_WIDTH=1, FIFO_DEPTH=4, `out_ready`=1. Stream 0x09,0x08,…,0x00: 80 contiguous beats, `serial_start` on beat 0 only. Required response: `out_data` sequence 09..00, each `out_valid` one cycle after its 8th beat, both flags 0.
- Same stream with `serial_en` low every other cycle and random `serial_output`/`serial_start` during idle cycles. Required response: identical 10-word sequence, flags 0.
- `out_ready`=0, push 0xA1..0xA5. Required response: after A4, `fifo_count`=4. On A5, `overflow`=1 and A5 is dropped. Then `out_ready`=1 yields A1,A2,A3,A4 on consecutive cycles.
- FIFO full (4 words). Pulse `out_ready` on the exact cycle a 5th word 0x5C completes. Required response: `fifo_count` stays 4, `overflow` stays 0, and 0x5C is drained last.
- Send 3 beats, then `serial_start` with word 0x3C. Required response: `partial_drop`=1 and the only word out is 0x3C. Then `clear_err`=1 for one cycle: `partial_drop`=0.
- Assert `reset` mid-word with 2 words queued. Required response: all outputs 0 immediately. A subsequent 0x7E stream produces exactly one word, 0x7E.
- Repeat the first scenario with SHIFT_WIDTH=2, 4 and 8 (BPW=4, 2, 1). Required response: the same data.

Source files
------------

// File: rtl/j_wgt_deserializer.sv
// Bit-serial weight receiver: reassembles LSB-first beats into 8-bit weights
// and queues them in a small circular FIFO with a registered valid/ready head.
module j_wgt_deserializer #(
  parameter int SHIFT_WIDTH = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SHIFT_WIDTH-1:0]        serial_output,
  input  logic                          serial_start,
  input  logic                          serial_en,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          partial_drop,
  input  logic                          clear_err
);

  localparam int BPW    = 8 / SHIFT_WIDTH;
  localparam int BEAT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPW - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [7:0]        asm_q, asm_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic              partial_drop_q, partial_drop_d;

  logic [BEAT_W-1:0] cur_beat;
  logic [7:0]        word;
  logic              push, pop, full, wr_en, ov_set, pd_set;

  always_comb begin
    beat_d   = beat_q;
    asm_d    = asm_q;
    cur_beat = beat_q;
    word     = asm_q;
    push     = 1'b0;
    pd_set   = 1'b0;
    if (serial_en) begin
      // A start beat always restarts the word at slice 0
      cur_beat = serial_start ? '0 : beat_q;
      pd_set   = serial_start && (beat_q != '0);
      for (int unsigned i = 0; i < BPW; i++) begin
        if (cur_beat == BEAT_W'(i)) begin
          word[i*SHIFT_WIDTH +: SHIFT_WIDTH] = serial_output;
        end
      end
      asm_d = word;
      if (cur_beat == LAST_BEAT) begin
        push   = 1'b1;
        beat_d = '0;
      end else begin
        beat_d = cur_beat + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    pop    = out_valid_q && out_ready;
    full   = (count_q == FULL_CNT);
    wr_en  = push && (!full || pop);
    ov_set = push && full && !pop;

    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = word;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    // Head is taken from the post-write image so a word pushed into an
    // empty FIFO is visible on out_data in the same cycle out_valid rises.
    out_valid_d = (count_d != '0);
    out_data_d  = out_data_q;
    if (count_d != '0) begin
      out_data_d = mem_d[rd_ptr_d];
    end

    overflow_d     = (clear_err ? 1'b0 : overflow_q) | ov_set;
    partial_drop_d = (clear_err ? 1'b0 : partial_drop_q) | pd_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q         <= '0;
      asm_q          <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      overflow_q     <= 1'b0;
      partial_drop_q <= 1'b0;
    end else begin
      beat_q         <= beat_d;
      asm_q          <= asm_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      overflow_q     <= overflow_d;
      partial_drop_q <= partial_drop_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign partial_drop = partial_drop_q;

endmodule

// File: tb/tb_j_wgt_deserializer.sv
// Randomised self-checking bench for j_wgt_deserializer at SHIFT_WIDTH 1/2/4/8
// against a queue-based behavioural model, plus literal checks of drained words.
module tb_j_wgt_deserializer;

  localparam int DEPTH = 4;
  localparam int SWS [4] = '{1, 2, 4, 8};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] so_a  [4];
  logic       se_a  [4];
  logic       ss_a  [4];
  logic       rdy_a [4];
  logic       ov_a  [4];
  logic       pd_a  [4];
  logic       val_a [4];
  logic [7:0] dat_a [4];
  logic [2:0] fc_a  [4];

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model state
  int         m_beat [4];
  int         m_asm  [4];
  int         m_head [4];
  int         m_cnt  [4];
  logic [7:0] m_q    [4][16];
  bit         m_ov   [4];
  bit         m_pd   [4];

  // words actually popped from each DUT
  int         log_n [4];
  logic [7:0] logv  [4][32];
  logic [7:0] exp_w [16];

  always #5 clk = ~clk;

  j_wgt_deserializer #(.SHIFT_WIDTH(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .clk(clk), .reset(rst), .serial_output(so_a[0][0:0]), .serial_start(ss_a[0]),
    .serial_en(se_a[0]), .out_valid(val_a[0]), .out_data(dat_a[0]), .out_ready(rdy_a[0]),
    .fifo_count(fc_a[0]), .overflow(ov_a[0]), .partial_drop(pd_a[0]), .clear_err(clr));
  j_wgt_deserializer #(.SHIFT_WIDTH(2), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .clk(clk), .reset(rst), .serial_output(so_a[1][1:0]), .serial_start(ss_a[1]),
    .serial_en(se_a[1]), .out_valid(val_a[1]), .out_data(dat_a[1]), .out_ready(rdy_a[1]),
    .fifo_count(fc_a[1]), .overflow(ov_a[1]), .partial_drop(pd_a[1]), .clear_err(clr));
  j_wgt_deserializer #(.SHIFT_WIDTH(4), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .reset(rst), .serial_output(so_a[2][3:0]), .serial_start(ss_a[2]),
    .serial_en(se_a[2]), .out_valid(val_a[2]), .out_data(dat_a[2]), .out_ready(rdy_a[2]),
    .fifo_count(fc_a[2]), .overflow(ov_a[2]), .partial_drop(pd_a[2]), .clear_err(clr));
  j_wgt_deserializer #(.SHIFT_WIDTH(8), .FIFO_DEPTH(DEPTH)) u_dut3 (
    .clk(clk), .reset(rst), .serial_output(so_a[3][7:0]), .serial_start(ss_a[3]),
    .serial_en(se_a[3]), .out_valid(val_a[3]), .out_data(dat_a[3]), .out_ready(rdy_a[3]),
    .fifo_count(fc_a[3]), .overflow(ov_a[3]), .partial_drop(pd_a[3]), .clear_err(clr));

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: words are built from bit positions, queued in arrival order,
  // and the queue length bounds acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_beat[k] = 0; m_asm[k] = 0; m_head[k] = 0; m_cnt[k] = 0;
        m_ov[k] = 1'b0; m_pd[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int sw, bpw, mask, shamt;
        bit pop, push, was_full, set_ov, set_pd;
        logic [7:0] pw;
        sw = SWS[k]; bpw = 8 / sw; mask = (1 << sw) - 1;
        push = 1'b0; set_ov = 1'b0; set_pd = 1'b0; pw = 8'h00;
        pop = (m_cnt[k] > 0) && rdy_a[k];
        was_full = (m_cnt[k] == DEPTH);
        if (se_a[k]) begin
          if (ss_a[k] && m_beat[k] != 0) set_pd = 1'b1;
          if (ss_a[k]) m_beat[k] = 0;
          shamt = m_beat[k] * sw;
          m_asm[k] = ((m_asm[k] & ~(mask << shamt)) | ((int'(so_a[k]) & mask) << shamt)) & 255;
          if (m_beat[k] == bpw - 1) begin
            push = 1'b1; pw = 8'(m_asm[k]); m_beat[k] = 0;
          end else begin
            m_beat[k]++;
          end
        end
        if (pop) begin
          m_head[k] = (m_head[k] + 1) % 16; m_cnt[k]--;
        end
        if (push) begin
          if (!was_full || pop) begin
            m_q[k][(m_head[k] + m_cnt[k]) % 16] = pw; m_cnt[k]++;
          end else begin
            set_ov = 1'b1;
          end
        end
        m_ov[k] = (clr ? 1'b0 : m_ov[k]) | set_ov;
        m_pd[k] = (clr ? 1'b0 : m_pd[k]) | set_pd;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("dut%0d out_valid", k), int'(val_a[k]), int'(m_cnt[k] > 0));
        chk($sformatf("dut%0d fifo_count", k), int'(fc_a[k]), m_cnt[k]);
        chk($sformatf("dut%0d overflow", k), int'(ov_a[k]), int'(m_ov[k]));
        chk($sformatf("dut%0d partial_drop", k), int'(pd_a[k]), int'(m_pd[k]));
        if (m_cnt[k] > 0)
          chk($sformatf("dut%0d out_data", k), int'(dat_a[k]), int'(m_q[k][m_head[k]]));
        if (val_a[k] && rdy_a[k] && log_n[k] < 32) begin
          logv[k][log_n[k]] = dat_a[k];
          log_n[k]++;
        end
      end
    end
  end

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      se_a[k] = 1'b0; ss_a[k] = 1'($urandom); so_a[k] = 8'($urandom);
    end
  endtask

  task automatic quiet(int n);
    repeat (n) begin
      @(posedge clk); #1;
      idle_all();
    end
  endtask

  task automatic beat(int k, logic [7:0] v, logic st);
    @(posedge clk); #1;
    idle_all();
    se_a[k] = 1'b1; ss_a[k] = st; so_a[k] = v;
  endtask

  task automatic send_word(int k, logic [7:0] w, bit gap, bit rdy_last);
    int sw, bpw;
    logic [7:0] sh;
    sw = SWS[k]; bpw = 8 / sw;
    for (int i = 0; i < bpw; i++) begin
      if (gap) quiet(1);
      sh = w >> (i * sw);
      beat(k, sh & 8'((1 << sw) - 1), (i == 0));
      if (rdy_last && i == bpw - 1) rdy_a[k] = 1'b1;
    end
  endtask

  task automatic check_log(int k, int n, string nm);
    chk({nm, " word count"}, log_n[k], n);
    for (int i = 0; i < n && i < log_n[k]; i++)
      chk($sformatf("%s word %0d", nm, i), int'(logv[k][i]), int'(exp_w[i]));
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 4; k++) log_n[k] = 0;
  endtask

  task automatic desc_stream(int k, bit gap, string nm);
    clear_logs();
    rdy_a[k] = 1'b1;
    for (int w = 9; w >= 0; w--) send_word(k, 8'(w), gap, 1'b0);
    quiet(4);
    for (int i = 0; i < 10; i++) exp_w[i] = 8'(9 - i);
    check_log(k, 10, nm);
    chk({nm, " overflow"}, int'(ov_a[k]), 0);
    chk({nm, " partial_drop"}, int'(pd_a[k]), 0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      so_a[k] = '0; se_a[k] = 1'b0; ss_a[k] = 1'b0; rdy_a[k] = 1'b0; log_n[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", int'(val_a[0]), 0);
    chk("reset fifo_count", int'(fc_a[0]), 0);
    rst = 1'b0;

    desc_stream(0, 1'b0, "contig sw1");
    desc_stream(0, 1'b1, "gapped sw1");

    // overflow: four words fill the FIFO, the fifth is dropped
    clear_logs();
    rdy_a[0] = 1'b0;
    for (int w = 'hA1; w <= 'hA4; w++) send_word(0, 8'(w), 1'b0, 1'b0);
    quiet(1);
    chk("fill fifo_count", int'(fc_a[0]), 4);
    chk("fill overflow", int'(ov_a[0]), 0);
    send_word(0, 8'hA5, 1'b0, 1'b0);
    quiet(1);
    chk("drop overflow", int'(ov_a[0]), 1);
    chk("drop fifo_count", int'(fc_a[0]), 4);
    rdy_a[0] = 1'b1;
    quiet(6);
    for (int i = 0; i < 4; i++) exp_w[i] = 8'('hA1 + i);
    check_log(0, 4, "overflow drain");
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    chk("clear overflow", int'(ov_a[0]), 0);

    // push and pop on the same edge with the FIFO full
    clear_logs();
    rdy_a[0] = 1'b0;
    for (int w = 'h11; w <= 'h14; w++) send_word(0, 8'(w), 1'b0, 1'b0);
    send_word(0, 8'h5C, 1'b0, 1'b1);
    @(posedge clk); #1;
    idle_all();
    rdy_a[0] = 1'b0;
    chk("pushpop fifo_count", int'(fc_a[0]), 4);
    chk("pushpop overflow", int'(ov_a[0]), 0);
    rdy_a[0] = 1'b1;
    quiet(6);
    exp_w[0] = 8'h11; exp_w[1] = 8'h12; exp_w[2] = 8'h13; exp_w[3] = 8'h14; exp_w[4] = 8'h5C;
    check_log(0, 5, "pushpop drain");

    // start arriving mid-word discards the partial word
    clear_logs();
    beat(0, 8'h1, 1'b1);
    beat(0, 8'h0, 1'b0);
    beat(0, 8'h1, 1'b0);
    send_word(0, 8'h3C, 1'b0, 1'b0);
    quiet(3);
    chk("restart partial_drop", int'(pd_a[0]), 1);
    exp_w[0] = 8'h3C;
    check_log(0, 1, "restart");
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    chk("clear partial_drop", int'(pd_a[0]), 0);

    // asynchronous reset mid-word with two words queued
    rdy_a[0] = 1'b0;
    send_word(0, 8'h21, 1'b0, 1'b0);
    send_word(0, 8'h22, 1'b0, 1'b0);
    beat(0, 8'h1, 1'b1);
    beat(0, 8'h1, 1'b0);
    beat(0, 8'h1, 1'b0);
    quiet(1);
    chk("pre-reset fifo_count", int'(fc_a[0]), 2);
    #2 rst = 1'b1;
    #1;
    chk("async reset out_valid", int'(val_a[0]), 0);
    chk("async reset out_data", int'(dat_a[0]), 0);
    chk("async reset fifo_count", int'(fc_a[0]), 0);
    chk("async reset overflow", int'(ov_a[0]), 0);
    chk("async reset partial_drop", int'(pd_a[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    rdy_a[0] = 1'b1;
    send_word(0, 8'h7E, 1'b0, 1'b0);
    quiet(4);
    exp_w[0] = 8'h7E;
    check_log(0, 1, "post-reset");
    chk("post-reset partial_drop", int'(pd_a[0]), 0);

    desc_stream(1, 1'b0, "contig sw2");
    desc_stream(2, 1'b0, "contig sw4");
    desc_stream(3, 1'b0, "contig sw8");
    desc_stream(1, 1'b1, "gapped sw2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
